// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: CSR read/modify/write, counters, interrupt sync,
// trap/MRET redirect and commit kill, all resolved in the committing cycle.
module csr_trap_unit #(
    parameter int unsigned      XLEN      = 32,
    parameter int unsigned      CNT_W     = 64,
    parameter logic [XLEN-1:0]  MTVEC_RST = '0,
    parameter logic [XLEN-1:0]  HART_ID   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            commit_valid_i,
    input  logic [XLEN-1:0] commit_pc_i,
    input  logic [2:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            trap_valid_o,
    output logic [XLEN-1:0] trap_target_o,
    output logic            inst_kill_o
);

    localparam int unsigned     PadW      = 2 * XLEN;
    localparam logic [XLEN-1:0] AlignMask = {{(XLEN - 2){1'b1}}, 2'b00};

    logic              mstatus_mie_q, mstatus_mie_d;
    logic              mstatus_mpie_q, mstatus_mpie_d;
    logic              mie_mtie_q, mie_mtie_d;
    logic              mie_meie_q, mie_meie_d;
    logic [XLEN-1:0]   mtvec_q, mtvec_d;
    logic [XLEN-1:0]   mepc_q, mepc_d;
    logic [XLEN-1:0]   mcause_q, mcause_d;
    logic [XLEN-1:0]   mscratch_q, mscratch_d;
    logic [CNT_W-1:0]  mcycle_q, mcycle_d;
    logic [CNT_W-1:0]  minstret_q, minstret_d;
    logic [1:0]        tmr_sync_q, ext_sync_q;

    logic              mip_mtip, mip_meip;
    logic [PadW-1:0]   mcycle_pad, minstret_pad;
    logic [XLEN-1:0]   csr_old, csr_wval, mtvec_base;
    logic              csr_impl, csr_ro;
    logic              op_rw, op_rs, op_rc, op_ecall, op_ebreak, op_mret, op_csr;
    logic              wr_eff, illegal, tmr_pend, ext_pend;
    logic              take_trap, is_irq, do_mret, do_csr_wr;
    logic [3:0]        cause_code;

    assign mip_mtip     = tmr_sync_q[1];
    assign mip_meip     = ext_sync_q[1];
    assign mcycle_pad   = PadW'(mcycle_q);
    assign minstret_pad = PadW'(minstret_q);
    assign mtvec_base   = mtvec_q & AlignMask;

    assign op_rw     = (csr_op_i == 3'b001);
    assign op_rs     = (csr_op_i == 3'b010);
    assign op_rc     = (csr_op_i == 3'b011);
    assign op_ecall  = (csr_op_i == 3'b100);
    assign op_ebreak = (csr_op_i == 3'b101);
    assign op_mret   = (csr_op_i == 3'b110);
    assign op_csr    = op_rw | op_rs | op_rc;
    // Set/clear with a zero mask is a pure read, hence legal on read-only CSRs.
    assign wr_eff    = op_rw | ((op_rs | op_rc) & (|csr_wdata_i));
    assign illegal   = op_csr & (~csr_impl | (csr_ro & wr_eff));
    assign tmr_pend  = mip_mtip & mie_mtie_q & mstatus_mie_q;
    assign ext_pend  = mip_meip & mie_meie_q & mstatus_mie_q;

    always_comb begin
        csr_impl = 1'b1;
        csr_ro   = 1'b0;
        csr_old  = '0;
        case (csr_addr_i)
            12'h300: begin
                csr_old[12:11] = 2'b11;
                csr_old[7]     = mstatus_mpie_q;
                csr_old[3]     = mstatus_mie_q;
            end
            12'h304: begin
                csr_old[7]  = mie_mtie_q;
                csr_old[11] = mie_meie_q;
            end
            12'h305: csr_old = mtvec_q;
            12'h340: csr_old = mscratch_q;
            12'h341: csr_old = mepc_q;
            12'h342: csr_old = mcause_q;
            12'h344: begin
                csr_ro      = 1'b1;
                csr_old[7]  = mip_mtip;
                csr_old[11] = mip_meip;
            end
            12'hB00: csr_old = mcycle_pad[XLEN-1:0];
            12'hB02: csr_old = minstret_pad[XLEN-1:0];
            12'hB80: begin
                if (XLEN == 32) csr_old = mcycle_pad[PadW-1:XLEN];
                else            csr_impl = 1'b0;
            end
            12'hB82: begin
                if (XLEN == 32) csr_old = minstret_pad[PadW-1:XLEN];
                else            csr_impl = 1'b0;
            end
            12'hF14: begin
                csr_ro  = 1'b1;
                csr_old = HART_ID;
            end
            default: csr_impl = 1'b0;
        endcase
    end

    always_comb begin
        unique case (csr_op_i)
            3'b001:  csr_wval = csr_wdata_i;
            3'b010:  csr_wval = csr_old | csr_wdata_i;
            3'b011:  csr_wval = csr_old & ~csr_wdata_i;
            default: csr_wval = csr_old;
        endcase
    end

    always_comb begin
        take_trap   = 1'b0;
        is_irq      = 1'b0;
        inst_kill_o = 1'b0;
        cause_code  = 4'd0;
        do_mret     = 1'b0;
        do_csr_wr   = 1'b0;
        if (commit_valid_i) begin
            if (ext_pend) begin
                take_trap   = 1'b1;
                is_irq      = 1'b1;
                inst_kill_o = 1'b1;
                cause_code  = 4'd11;
            end else if (tmr_pend) begin
                take_trap   = 1'b1;
                is_irq      = 1'b1;
                inst_kill_o = 1'b1;
                cause_code  = 4'd7;
            end else if (illegal) begin
                take_trap   = 1'b1;
                inst_kill_o = 1'b1;
                cause_code  = 4'd2;
            end else if (op_ecall) begin
                take_trap  = 1'b1;
                cause_code = 4'd11;
            end else if (op_ebreak) begin
                take_trap  = 1'b1;
                cause_code = 4'd3;
            end else if (op_mret) begin
                do_mret = 1'b1;
            end else if (op_csr && wr_eff) begin
                do_csr_wr = 1'b1;
            end
        end
        trap_valid_o  = take_trap | do_mret;
        trap_target_o = mtvec_base;
        if (do_mret) begin
            trap_target_o = mepc_q;
        end else if (is_irq && mtvec_q[1:0] == 2'b01) begin
            trap_target_o = mtvec_base + XLEN'({cause_code, 2'b00});
        end
    end

    assign csr_rdata_o = csr_old;

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mscratch_d     = mscratch_q;
        mcycle_d       = mcycle_q + {{(CNT_W - 1){1'b0}}, 1'b1};
        minstret_d     = minstret_q + {{(CNT_W - 1){1'b0}}, commit_valid_i & ~take_trap};
        if (take_trap) begin
            mepc_d         = commit_pc_i & AlignMask;
            mcause_d       = {is_irq, (XLEN - 1)'(cause_code)};
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end
        if (do_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
        // Counter writes replace this cycle's increment; the untouched half gets no carry.
        if (do_csr_wr) begin
            case (csr_addr_i)
                12'h300: begin
                    mstatus_mie_d  = csr_wval[3];
                    mstatus_mpie_d = csr_wval[7];
                end
                12'h304: begin
                    mie_mtie_d = csr_wval[7];
                    mie_meie_d = csr_wval[11];
                end
                12'h305: mtvec_d    = csr_wval[1] ? (csr_wval & AlignMask) : csr_wval;
                12'h340: mscratch_d = csr_wval;
                12'h341: mepc_d     = csr_wval & AlignMask;
                12'h342: mcause_d   = csr_wval;
                12'hB00: mcycle_d   = CNT_W'({mcycle_pad[PadW-1:XLEN], csr_wval});
                12'hB02: minstret_d = CNT_W'({minstret_pad[PadW-1:XLEN], csr_wval});
                12'hB80: if (XLEN == 32) mcycle_d = CNT_W'({csr_wval, mcycle_pad[XLEN-1:0]});
                12'hB82: if (XLEN == 32) minstret_d = CNT_W'({csr_wval, minstret_pad[XLEN-1:0]});
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RST;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mscratch_q     <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
            tmr_sync_q     <= 2'b00;
            ext_sync_q     <= 2'b00;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mscratch_q     <= mscratch_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
            tmr_sync_q     <= {tmr_sync_q[0], irq_timer_i};
            ext_sync_q     <= {ext_sync_q[0], irq_ext_i};
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: expectations queued per driven cycle, checked before the edge.
module tb_csr_trap_unit;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            commit_valid = 1'b0;
    logic [XLEN-1:0] commit_pc = '0;
    logic [2:0]      csr_op = 3'b000;
    logic [11:0]     csr_addr = 12'h000;
    logic [XLEN-1:0] csr_wdata = '0;
    logic            irq_timer = 1'b0;
    logic            irq_ext = 1'b0;
    logic [XLEN-1:0] csr_rdata;
    logic            trap_valid;
    logic [XLEN-1:0] trap_target;
    logic            inst_kill;

    csr_trap_unit #(
        .XLEN      (XLEN),
        .CNT_W     (64),
        .MTVEC_RST (32'h0000_0040),
        .HART_ID   (32'h0000_0005)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid_i (commit_valid),
        .commit_pc_i    (commit_pc),
        .csr_op_i       (csr_op),
        .csr_addr_i     (csr_addr),
        .csr_wdata_i    (csr_wdata),
        .irq_timer_i    (irq_timer),
        .irq_ext_i      (irq_ext),
        .csr_rdata_o    (csr_rdata),
        .trap_valid_o   (trap_valid),
        .trap_target_o  (trap_target),
        .inst_kill_o    (inst_kill)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc_n = 0;
    logic [63:0] ret_n = '0;

    localparam logic [2:0] OpNone = 3'b000, OpRw = 3'b001, OpRs = 3'b010, OpRc = 3'b011;
    localparam logic [2:0] OpEcall = 3'b100, OpEbreak = 3'b101, OpMret = 3'b110;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            0:       return 64'(csr_rdata);
            1:       return 64'(trap_valid);
            2:       return 64'(trap_target);
            default: return 64'(inst_kill);
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Inputs change at negedge; outputs are combinational, so check them before the posedge.
    task automatic step();
        exp_t e;
        #2;
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.sel), e.exp);
        end
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
        commit_valid = 1'b0;
        csr_op       = OpNone;
    endtask

    task automatic idle();
        commit_valid = 1'b0;
        csr_op       = OpNone;
        step();
    endtask

    task automatic peek(input string tag, input logic [11:0] addr, input logic [63:0] exp);
        commit_valid = 1'b0;
        csr_op       = OpNone;
        csr_addr     = addr;
        csr_wdata    = '0;
        push(tag, 0, exp);
        step();
    endtask

    task automatic commit(input string tag, input logic [31:0] pc, input logic [2:0] op,
                          input logic [11:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input bit exp_tv,
                          input logic [31:0] exp_tgt, input bit exp_kill, input bit retires);
        commit_valid = 1'b1;
        commit_pc    = pc;
        csr_op       = op;
        csr_addr     = addr;
        csr_wdata    = wd;
        push({tag, ".rdata"}, 0, 64'(exp_rd));
        push({tag, ".trap_valid"}, 1, 64'(exp_tv));
        push({tag, ".inst_kill"}, 3, 64'(exp_kill));
        if (exp_tv) push({tag, ".target"}, 2, 64'(exp_tgt));
        step();
        if (retires) ret_n++;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        push("reset.trap_valid", 1, 64'd0);
        push("reset.inst_kill", 3, 64'd0);
        peek("reset.mstatus", 12'h300, 64'h1800);
        peek("reset.mtvec", 12'h305, 64'h40);
        peek("reset.mhartid", 12'hF14, 64'h5);
        repeat (7) idle();
        peek("reset.mcycle", 12'hB00, 64'(cyc_n));
        peek("reset.minstret", 12'hB02, ret_n);

        // ECALL / MRET in direct mode
        commit("wr_mtvec", 32'h100, OpRw, 12'h305, 32'h100, 32'h40, 0, 0, 0, 1);
        commit("set_mie", 32'h104, OpRs, 12'h300, 32'h8, 32'h1800, 0, 0, 0, 1);
        commit("ecall", 32'h8000_0010, OpEcall, 12'h000, 0, 0, 1, 32'h100, 0, 0);
        peek("ecall.mepc", 12'h341, 64'h8000_0010);
        peek("ecall.mcause", 12'h342, 64'd11);
        peek("ecall.minstret", 12'hB02, ret_n);
        peek("ecall.mstatus", 12'h300, 64'h1880);
        commit("mret", 32'h108, OpMret, 12'h000, 0, 0, 1, 32'h8000_0010, 0, 1);
        peek("mret.mstatus", 12'h300, 64'h1888);
        peek("mret.minstret", 12'hB02, ret_n);

        // Vectored timer interrupt, two-flop synchroniser latency
        commit("wr_mtvec_vec", 32'h200, OpRw, 12'h305, 32'h201, 32'h100, 0, 0, 0, 1);
        commit("wr_mie_mtie", 32'h204, OpRw, 12'h304, 32'h80, 32'h0, 0, 0, 0, 1);
        irq_timer = 1'b1;
        commit("tmr_edge0", 32'h208, OpNone, 12'h000, 0, 0, 0, 0, 0, 1);
        commit("tmr_edge1", 32'h20C, OpNone, 12'h000, 0, 0, 0, 0, 0, 1);
        commit("tmr_irq", 32'h1000, OpNone, 12'h000, 0, 0, 1, 32'h21C, 1, 0);
        peek("tmr.mcause", 12'h342, 64'h8000_0007);
        peek("tmr.mstatus", 12'h300, 64'h1880);
        peek("tmr.mip", 12'h344, 64'h80);

        // External beats timer beats ECALL
        irq_ext = 1'b1;
        commit("set_meie", 32'h1004, OpRs, 12'h304, 32'h800, 32'h80, 0, 0, 0, 1);
        commit("mret2", 32'h1008, OpMret, 12'h000, 0, 0, 1, 32'h1000, 0, 1);
        commit("ext_vs_ecall", 32'h2000, OpEcall, 12'h000, 0, 0, 1, 32'h22C, 1, 0);
        peek("ext.mcause", 12'h342, 64'h8000_000B);
        peek("ext.mepc", 12'h341, 64'h2000);
        irq_ext   = 1'b0;
        irq_timer = 1'b0;

        // Illegal CSR accesses and legal zero-mask read of a read-only CSR
        commit("wr_hartid", 32'h3000, OpRw, 12'hF14, 32'h1, 32'h5, 1, 32'h200, 1, 0);
        peek("ill.mcause", 12'h342, 64'd2);
        peek("ill.mhartid", 12'hF14, 64'h5);
        commit("wr_unimpl", 32'h3004, OpRw, 12'h7C0, 32'h1234, 32'h0, 1, 32'h200, 1, 0);
        peek("ill.mepc", 12'h341, 64'h3004);
        commit("rs0_hartid", 32'h3008, OpRs, 12'hF14, 32'h0, 32'h5, 0, 0, 0, 1);
        commit("ebreak", 32'h300C, OpEbreak, 12'h000, 0, 0, 1, 32'h200, 0, 0);
        peek("ebreak.mcause", 12'h342, 64'd3);

        // Set/clear on mscratch
        commit("scr_rw", 32'h400, OpRw, 12'h340, 32'hA5A5, 32'h0, 0, 0, 0, 1);
        commit("scr_rs", 32'h404, OpRs, 12'h340, 32'h0F00, 32'hA5A5, 0, 0, 0, 1);
        commit("scr_rc", 32'h408, OpRc, 12'h340, 32'h00A5, 32'hAFA5, 0, 0, 0, 1);
        peek("scr.final", 12'h340, 64'hAF00);

        // Counter half writes, carry into mcycleh, minstret write override
        commit("wr_mcycle", 32'h500, OpRw, 12'hB00, 32'hFFFF_FFFF, 32'(cyc_n), 0, 0, 0, 1);
        idle();
        idle();
        peek("mcycleh.carry", 12'hB80, 64'h1);
        peek("mcycle.low", 12'hB00, 64'h2);
        commit("wr_minstret", 32'h504, OpRw, 12'hB02, 32'h55, 32'(ret_n), 0, 0, 0, 0);
        ret_n = 64'h55;
        peek("minstret.written", 12'hB02, ret_n);
        commit("retire", 32'h508, OpNone, 12'h000, 0, 0, 0, 0, 0, 1);
        peek("minstret.inc", 12'hB02, ret_n);
        peek("minstreth", 12'hB82, 64'h0);

        // mtvec mode 3 collapses to direct
        commit("wr_mtvec_m3", 32'h600, OpRw, 12'h305, 32'h303, 32'h201, 0, 0, 0, 1);
        peek("mtvec.mode3", 12'h305, 64'h300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
